// File: rtl/rps_scoreboard_if.sv
// Judge-to-scoreboard bus: verdict level and match control in, score/LED state out.
interface rps_scoreboard_if;
  logic [2:0] result;
  logic       new_match;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [3:0] draws;
  logic [3:0] rounds;
  logic       round_done;
  logic       match_over;
  logic [1:0] winner;
  logic       led_p1;
  logic       led_p2;

  modport master (
    output result, new_match,
    input  score1, score2, draws, rounds, round_done, match_over, winner, led_p1, led_p2
  );
  modport slave (
    input  result, new_match,
    output score1, score2, draws, rounds, round_done, match_over, winner, led_p1, led_p2
  );
endinterface

// File: rtl/rps_scoreboard.sv
// Rock-paper-scissors match scoreboard: counts each held judge verdict once,
// declares first-to-TARGET or a tie at MAX_ROUNDS, and blinks winner LEDs.
module rps_scoreboard #(
  parameter int TARGET     = 3,
  parameter int MAX_ROUNDS = 15,
  parameter int BLINK_DIV  = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  rps_scoreboard_if.slave sb
);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {PLAY, P1_WON, P2_WON, TIE} state_t;

  state_t        r_state;
  logic [3:0]    r_s1, r_s2, r_d, r_rnd;
  logic          r_rd, r_mo, r_armed, r_phase, r_led1, r_led2;
  logic [1:0]    r_win;
  logic [BW-1:0] r_bcnt;

  state_t        w_state;
  logic [3:0]    w_s1, w_s2, w_d, w_rnd;
  logic          w_zero, w_onehot, w_count, w_phase, w_led1, w_led2;
  logic [BW-1:0] w_bcnt;

  assign w_zero   = (sb.result == 3'b000);
  assign w_onehot = (sb.result == 3'b100) || (sb.result == 3'b010) || (sb.result == 3'b001);
  assign w_count  = r_armed && w_onehot && (r_state == PLAY);

  // Match decision uses the post-increment counts of this same edge.
  always_comb begin
    w_s1    = r_s1;
    w_s2    = r_s2;
    w_d     = r_d;
    w_rnd   = r_rnd;
    w_state = r_state;
    if (w_count) begin
      w_rnd = r_rnd + 4'd1;
      if (sb.result[2]) w_s1 = r_s1 + 4'd1;
      if (sb.result[1]) w_s2 = r_s2 + 4'd1;
      if (sb.result[0]) w_d  = r_d + 4'd1;
      if (w_s1 == 4'(TARGET))           w_state = P1_WON;
      else if (w_s2 == 4'(TARGET))      w_state = P2_WON;
      else if (w_rnd == 4'(MAX_ROUNDS)) w_state = TIE;
    end
  end

  // Blink phase starts high on entry into a finished state.
  always_comb begin
    w_bcnt  = '0;
    w_phase = 1'b0;
    if (r_state == PLAY) begin
      if (w_state != PLAY) w_phase = 1'b1;
    end else if (r_bcnt == BLINK_LAST) begin
      w_phase = ~r_phase;
    end else begin
      w_bcnt  = r_bcnt + 1'b1;
      w_phase = r_phase;
    end
  end

  always_comb begin
    w_led1 = 1'b0;
    w_led2 = 1'b0;
    case (w_state)
      PLAY:    begin w_led1 = (w_s1 > w_s2); w_led2 = (w_s2 > w_s1); end
      P1_WON:  w_led1 = w_phase;
      P2_WON:  w_led2 = w_phase;
      default: begin w_led1 = w_phase; w_led2 = w_phase; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || sb.new_match) begin
      r_state <= PLAY;
      r_s1    <= '0;
      r_s2    <= '0;
      r_d     <= '0;
      r_rnd   <= '0;
      r_rd    <= 1'b0;
      r_mo    <= 1'b0;
      r_win   <= 2'b00;
      r_armed <= 1'b0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      r_led1  <= 1'b0;
      r_led2  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_s1    <= w_s1;
      r_s2    <= w_s2;
      r_d     <= w_d;
      r_rnd   <= w_rnd;
      r_rd    <= w_count;
      r_mo    <= (w_state != PLAY);
      r_win   <= w_state;
      r_bcnt  <= w_bcnt;
      r_phase <= w_phase;
      r_led1  <= w_led1;
      r_led2  <= w_led2;
      // Multi-bit codes leave armed untouched; one-hot consumes it.
      if (w_zero)        r_armed <= 1'b1;
      else if (w_onehot) r_armed <= 1'b0;
    end
  end

  assign sb.score1     = r_s1;
  assign sb.score2     = r_s2;
  assign sb.draws      = r_d;
  assign sb.rounds     = r_rnd;
  assign sb.round_done = r_rd;
  assign sb.match_over = r_mo;
  assign sb.winner     = r_win;
  assign sb.led_p1     = r_led1;
  assign sb.led_p2     = r_led2;
endmodule

// File: tb/tb_rps_scoreboard.sv
// Table-driven bench for rps_scoreboard with a queue scoreboard of expected outputs.
module tb_rps_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rps_scoreboard_if sbif();

  rps_scoreboard #(.TARGET(3), .MAX_ROUNDS(5), .BLINK_DIV(4)) dut (
    .clk(clk), .rst(rst), .sb(sbif)
  );

  typedef struct {
    logic       rst, nm;
    logic [2:0] res;
    logic [3:0] s1, s2, d, r;
    logic       rd, mo;
    logic [1:0] win;
    logic       l1, l2;
  } vec_t;

  vec_t        vecs[$];
  logic [21:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic add(input logic r, input logic nm, input logic [2:0] res,
                     input int s1, input int s2, input int d, input int rn,
                     input logic rd, input logic mo, input logic [1:0] win,
                     input logic l1, input logic l2);
    vec_t v;
    v.rst = r; v.nm = nm; v.res = res;
    v.s1 = 4'(s1); v.s2 = 4'(s2); v.d = 4'(d); v.r = 4'(rn);
    v.rd = rd; v.mo = mo; v.win = win; v.l1 = l1; v.l2 = l2;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [21:0] e, got;
    @(negedge clk);
    rst = v.rst; sbif.new_match = v.nm; sbif.result = v.res;
    exp_q.push_back({v.s1, v.s2, v.d, v.r, v.rd, v.mo, v.win, v.l1, v.l2});
    @(posedge clk);
    #1;
    got = {sbif.score1, sbif.score2, sbif.draws, sbif.rounds, sbif.round_done,
           sbif.match_over, sbif.winner, sbif.led_p1, sbif.led_p2};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL vec%0d: got s1=%0d s2=%0d d=%0d r=%0d rd=%b mo=%b win=%b led=%b%b, want s1=%0d s2=%0d d=%0d r=%0d rd=%b mo=%b win=%b led=%b%b",
        idx, got[21:18], got[17:14], got[13:10], got[9:6], got[5], got[4], got[3:2], got[1], got[0],
        e[21:18], e[17:14], e[13:10], e[9:6], e[5], e[4], e[3:2], e[1], e[0]);
    end
  endtask

  initial begin
    int rd_seen;
    bit found;
    rst = 1'b1; sbif.new_match = 1'b0; sbif.result = 3'b000;

    // Single round, held verdict counts once.
    add(1,0,0, 0,0,0,0, 0,0,0, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0, 0,0);
    add(0,0,4, 1,0,0,1, 1,0,0, 1,0);
    repeat (9) add(0,0,4, 1,0,0,1, 0,0,0, 1,0);
    // Player-1 match win and blink.
    add(1,0,0, 0,0,0,0, 0,0,0, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0, 0,0);
    add(0,0,4, 1,0,0,1, 1,0,0, 1,0);
    add(0,0,0, 1,0,0,1, 0,0,0, 1,0);
    add(0,0,4, 2,0,0,2, 1,0,0, 1,0);
    add(0,0,0, 2,0,0,2, 0,0,0, 1,0);
    add(0,0,4, 3,0,0,3, 1,1,1, 1,0);
    repeat (2) add(0,0,0, 3,0,0,3, 0,1,1, 1,0);
    add(0,0,4, 3,0,0,3, 0,1,1, 1,0);
    repeat (4) add(0,0,0, 3,0,0,3, 0,1,1, 0,0);
    add(0,0,0, 3,0,0,3, 0,1,1, 1,0);
    // new_match, then tie on round limit.
    add(0,1,0, 0,0,0,0, 0,0,0, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0, 0,0);
    add(0,0,4, 1,0,0,1, 1,0,0, 1,0);
    add(0,0,0, 1,0,0,1, 0,0,0, 1,0);
    add(0,0,2, 1,1,0,2, 1,0,0, 0,0);
    add(0,0,0, 1,1,0,2, 0,0,0, 0,0);
    add(0,0,1, 1,1,1,3, 1,0,0, 0,0);
    add(0,0,0, 1,1,1,3, 0,0,0, 0,0);
    add(0,0,1, 1,1,2,4, 1,0,0, 0,0);
    add(0,0,0, 1,1,2,4, 0,0,0, 0,0);
    add(0,0,1, 1,1,3,5, 1,1,3, 1,1);
    repeat (3) add(0,0,0, 1,1,3,5, 0,1,3, 1,1);
    repeat (4) add(0,0,0, 1,1,3,5, 0,1,3, 0,0);
    repeat (2) add(0,0,0, 1,1,3,5, 0,1,3, 1,1);
    // Reset mid-blink.
    add(1,0,0, 0,0,0,0, 0,0,0, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0, 0,0);
    // Invalid and unarmed verdicts.
    add(0,0,4, 1,0,0,1, 1,0,0, 1,0);
    repeat (2) add(0,0,6, 1,0,0,1, 0,0,0, 1,0);
    repeat (2) add(0,0,7, 1,0,0,1, 0,0,0, 1,0);
    add(0,0,2, 1,0,0,1, 0,0,0, 1,0);
    add(0,0,0, 1,0,0,1, 0,0,0, 1,0);
    add(0,0,2, 1,1,0,2, 1,0,0, 0,0);
    add(0,0,0, 1,1,0,2, 0,0,0, 0,0);
    add(0,0,6, 1,1,0,2, 0,0,0, 0,0);
    add(0,0,2, 1,2,0,3, 1,0,0, 0,1);
    // new_match on the same edge as an armed verdict.
    add(0,0,0, 1,2,0,3, 0,0,0, 0,1);
    add(0,1,2, 0,0,0,0, 0,0,0, 0,0);
    add(0,0,2, 0,0,0,0, 0,0,0, 0,0);
    add(0,0,1, 0,0,0,0, 0,0,0, 0,0);
    // Mid-match reset with score2 = 2.
    add(0,0,0, 0,0,0,0, 0,0,0, 0,0);
    add(0,0,2, 0,1,0,1, 1,0,0, 0,1);
    add(0,0,0, 0,1,0,1, 0,0,0, 0,1);
    add(0,0,2, 0,2,0,2, 1,0,0, 0,1);
    add(1,0,0, 0,0,0,0, 0,0,0, 0,0);
    add(0,0,0, 0,0,0,0, 0,0,0, 0,0);
    add(0,0,2, 0,1,0,1, 1,0,0, 0,1);
    // Continue to a player-2 win.
    add(0,0,0, 0,1,0,1, 0,0,0, 0,1);
    add(0,0,2, 0,2,0,2, 1,0,0, 0,1);
    add(0,0,0, 0,2,0,2, 0,0,0, 0,1);
    add(0,0,2, 0,3,0,3, 1,1,2, 0,1);
    add(0,0,0, 0,3,0,3, 0,1,2, 0,1);

    foreach (vecs[i]) apply(vecs[i], i);

    // Hand sequence: bounded wait for a round_done pulse, then none during hold.
    @(negedge clk); rst = 1'b1; sbif.new_match = 1'b0; sbif.result = 3'b000;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); sbif.result = 3'b001;
    found = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin
      @(posedge clk); #1;
      if (sbif.round_done) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rd_wait: round_done not seen within 5 cycles, want pulse");
    end
    rd_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (sbif.round_done) rd_seen++;
    end
    checks++;
    if (rd_seen != 0 || sbif.draws != 4'd1) begin
      errors++;
      $display("FAIL rd_hold: extra pulses=%0d draws=%0d, want pulses=0 draws=1", rd_seen, sbif.draws);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rps_scoreboard.md
# rps_scoreboard

Match scoreboard for the rock-paper-scissors lab design. It sits directly downstream of the round judge and consumes its 3-bit held result level `{p1_win, p2_win, draw}`. It counts each judged round exactly once, tracks wins, draws and rounds, and declares a first-to-`TARGET` match winner or a tie on round exhaustion. It drives BCD-ready score outputs and winner LEDs.

## Interface
- `TARGET`, 3: wins needed to take the match; legal range 1..15.
- `MAX_ROUNDS`, 15: round limit; reaching it without a winner declares a tie; legal range 1..15.
- `BLINK_DIV`, 50_000_000: LED half-period in clk cycles; minimum 1.

- `clk` in 1: system clock, all logic on posedge.
- `rst` in 1: reset, synchronous, active-high; overrides every other input.
- `result` in 3: judge output `{p1_win, p2_win, draw}`, held level; 000 means no verdict.
- `new_match` in 1: single-cycle pulse that clears the scoreboard and starts a new match.
- `score1` out 4: player-1 wins.
- `score2` out 4: player-2 wins.
- `draws` out 4: drawn rounds.
- `rounds` out 4: rounds counted in the current match.
- `round_done` out 1: one-cycle pulse when a round is counted.
- `match_over` out 1: high in any finished state.
- `winner` out 2: 00 = none, 01 = player 1, 10 = player 2, 11 = tie.
- `led_p1` out 1: player-1 indicator.
- `led_p2` out 1: player-2 indicator.

## Operation
- Reset values: all counters 0, `round_done` 0, `match_over` 0, `winner` 00, both LEDs 0, `armed` 0, state `PLAY`, blink counter 0.
- Arming:
  - Internal `armed` sets on any edge where `result == 000`.
  - A round is counted on an edge where `armed == 1` and `result` is exactly one-hot (100, 010 or 001); that edge clears `armed`.
  - Multi-bit codes (011, 101, 110, 111) are ignored and leave `armed` unchanged.
  - A held verdict therefore counts once only. The judge returns to 000 when its reset or un-confirm occurs, which re-arms the scoreboard.
- Counting in `PLAY`:
  - Increment the matching counter (`score1`, `score2` or `draws`).
  - Increment `rounds`.
  - Pulse `round_done`.
- States: `PLAY`, `P1_WON`, `P2_WON`, `TIE`.
- Transitions are evaluated on the post-increment values, in the same edge as the count, with this priority:
  1. New `score1 == TARGET` → `P1_WON`.
  2. New `score2 == TARGET` → `P2_WON`.
  3. New `rounds == MAX_ROUNDS` → `TIE`.
  4. Otherwise stay in `PLAY`.
- Finished states:
  - Verdicts are ignored: no counting and no `round_done`.
  - `armed` still tracks the input.
  - `winner` = 01, 10 or 11 respectively; `match_over` = 1.
- `new_match`:
  - In any state, clears all counters, clears `armed` and the blink counter, and enters `PLAY`.
  - If a countable verdict arrives on the same edge, `new_match` wins and the verdict is discarded.
- LEDs:
  - `PLAY`: `led_p1 = (score1 > score2)`, `led_p2 = (score2 > score1)`, steady.
  - `P1_WON`: `led_p1` blinks and `led_p2` = 0.
  - `P2_WON`: the mirror of `P1_WON`.
  - `TIE`: both blink in phase.
  - Blink behaviour: the LED is 1 on entry to the finished state and toggles every `BLINK_DIV` cycles.
- Counters never wrap. The `TARGET` and `MAX_ROUNDS` limits stop counting first.

## Timing
- All outputs are registered.
- A verdict present before edge k with `armed = 1` is reflected after edge k in the following outputs:
  - counters
  - `round_done` (high for cycle k→k+1 only)
  - state
  - `match_over`
  - `winner`
- Minimum spacing between counted rounds is 2 cycles (one 000 cycle plus one verdict cycle).
- `rst` or `new_match` at edge k: all outputs hold their reset values after edge k; `round_done` is 0 in that cycle.
- Reset mid-blink: LEDs are 0 on the next cycle with no residual phase.
- Blink: with entry at edge k, the LED is 1 for cycles k..k+`BLINK_DIV`−1, then 0 for the next `BLINK_DIV` cycles, and so on.

## Test plan
Bench parameters: `TARGET` = 3, `MAX_ROUNDS` = 5, `BLINK_DIV` = 4.

- **Single round:** `rst`, then `result` 000 for 1 cycle, then 100 held for 10 cycles → `score1` = 1, exactly one `round_done` pulse, `rounds` = 1, LEDs = 10.
- **Player-1 match win:** three 000→100 sequences → after the third count `score1` = 3, `winner` = 01, `match_over` = 1. `led_p1` reads 1,1,1,1,0,0,0,0 over 8 cycles; `led_p2` = 0. A fourth 000→100 leaves `score1` = 3.
- **Tie on round limit:** verdict sequence 100, 010, 001, 001, 001 (each preceded by 000) → after the fifth count `draws` = 3, `rounds` = 5, `winner` = 11, both LEDs blink in phase.
- **Invalid and unarmed input:** 110 and 111 held, then 010 with no preceding 000 after a previous count → no count, `round_done` never asserts.
- **Simultaneous `new_match` and verdict:** `new_match` asserted on the same edge as an armed 010 → all counters 0, state `PLAY`, no `round_done`.
- **Mid-match reset:** `rst` asserted with `score2` = 2 → next cycle all outputs are 0 and `winner` = 00. A subsequent 000→010 gives `score2` = 1.
